seq_addsub: RTL and testbench
=============================

# seq_addsub

Parametrised multi-cycle adder/subtractor that replaces the fixed 32-bit combinational ripple adder wherever a result can take several cycles, such as multi-cycle execution and address generation. Each cycle it processes one CHUNK-bit slice of the operands through a ripple slice and holds the carry between slices in a register. It adds a subtract mode, true carry-out, signed overflow and zero flags, and a start/done handshake, so area can be traded against latency through parameters.

## Interface
- WIDTH, 32: operand and result width; ≥ 2.
- CHUNK, 8: bits processed per cycle; must divide WIDTH exactly. NCH = WIDTH/CHUNK.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when the block is idle or in its done cycle
- sub  in  1  0 = x+y, 1 = x−y; latched with start
- x  in  WIDTH  operand A; latched with start
- y  in  WIDTH  operand B; latched with start
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: results are valid and newly updated
- sum  out  WIDTH  result
- cout  out  1  carry out of the MSB; for sub, 1 means x ≥ y unsigned (no borrow)
- ov  out  1  signed overflow: carry into MSB XOR carry out of MSB
- zero  out  1  sum == 0

## Operation
- States:
  - IDLE: accepts start.
  - RUN: processes slices.
  - DONE: done=1 for one cycle; accepts start.
- IDLE/DONE with start=1:
  - latch x, and y XOR {WIDTH{sub}}.
  - carry register ← sub.
  - slice counter ← 0; go to RUN.
- DONE with start=0: go to IDLE.
- RUN, each cycle:
  - slice i = counter: bits [i·CHUNK +: CHUNK] are added with the carry register.
  - the slice result is written into the working sum register; the carry register takes the slice carry-out.
  - the counter increments.
- RUN with counter == NCH−1: after that edge, go to DONE. At the same edge, sum/cout/ov/zero load from the working result.
- ov uses the carry into bit WIDTH−1, which is internal to the last slice.
- zero is computed from the final full-width sum.
- sum/cout/ov/zero change only at the edge that raises done. They hold until the next done.
- start while busy=1 is ignored: no queuing, no error.
- Mid-operation changes to x/y/sub have no effect.
- Arithmetic is modulo 2^WIDTH. Signed and unsigned interpretation differ only in ov versus cout.

## Timing
- Reset (async assert, sync release by the system):
  - state IDLE; busy=0, done=0.
  - sum=0, cout=0, ov=0, zero=0.
  - internal counter and carry cleared.
- Reset asserted mid-RUN aborts the operation immediately. The partial result is discarded and never flagged by done.
- Latency: start sampled at edge E0 → busy=1 from E0 through E(NCH) → done=1 during the cycle after E(NCH) → busy=0 in that cycle.
- Throughput: with start held during the DONE cycle, operations issue back-to-back. Period is NCH+1 cycles.
- NCH=1 (CHUNK=WIDTH): done rises one cycle after start.
- Outputs are fully registered. No combinational path from inputs to outputs.

## Structure
- Shared package `addsub_pkg`:
  - state enum {IDLE, RUN, DONE}.
  - function computing the counter width, $clog2(NCH) clamped to a minimum of 1.
- Sub-module `chunk_adder`: CHUNK-bit ripple of the existing full_adder cells.
  - ports: a, b, cin, s, cout, and cmsb (carry into the slice MSB).
  - one instance, reused every cycle.
- Top-level contents: FSM, slice counter, operand registers, carry register, working sum register, result registers.
- Slice selection is done with the counter-indexed part-select.

## Test plan
WIDTH=32, CHUNK=8 unless stated.
- add 0x7FFFFFFF + 0x00000001 → done 4 cycles after start; sum=0x80000000, cout=0, ov=1, zero=0.
- add 0xFFFFFFFF + 0x00000001 → sum=0x00000000, cout=1, ov=0, zero=1. Check the carry crosses all three slice boundaries.
- sub 5 − 7 → sum=0xFFFFFFFE, cout=0, ov=0. sub 0x80000000 − 1 → sum=0x7FFFFFFF, cout=1, ov=1.
- start during RUN with new operands → ignored; first result unchanged. Start held in the done cycle → second done exactly 5 cycles after the first.
- rst_n low on cycle 2 of RUN → all outputs 0 immediately, no done pulse. Next start completes normally with the correct result.
- Parameters: CHUNK=32 gives done 1 cycle after start; CHUNK=1 gives done at 32 cycles. Randomised operands and mode checked against a reference model for WIDTH=16, CHUNK=4.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the sequential adder/subtractor.
package addsub_pkg;

  // Controller states
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Slice-counter width: $clog2(nch), never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned nch);
    return (nch > 2) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple-carry slice built from full_adder cells.
// Besides the carry out it exposes the carry into the slice MSB, which
// the top level needs for signed overflow on the final slice.
module chunk_adder #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] s_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  // c[i] is the carry into bit i; c[CHUNK] leaves the slice.
  logic [CHUNK:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a_i  (a_i[i]),
      .b_i  (b_i[i]),
      .ci_i (c[i]),
      .s_o  (s_o[i]),
      .co_o (c[i+1])
    );
  end

  assign cout_o = c[CHUNK];
  assign cmsb_o = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per cycle through a
// single shared ripple slice, carry held in a register between slices.
// Results (sum/cout/ov/zero) are registered and update only when done rises.
module seq_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ov_o,
  output logic             zero_o
);

  localparam int unsigned NCH  = WIDTH / CHUNK;
  localparam int unsigned CntW = cnt_width(NCH);
  localparam int unsigned OffW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(NCH - 1);

  if ((WIDTH < 2) || (CHUNK == 0) || (WIDTH % CHUNK != 0)) begin : g_param_check
    $error("seq_addsub: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;     // y, pre-inverted for subtract
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  work_q, work_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ov_q, ov_d;
  logic              zero_q, zero_d;

  logic [OffW-1:0]   off;
  logic [CHUNK-1:0]  slice_a, slice_b, slice_s;
  logic              slice_cout, slice_cmsb;
  logic [WIDTH-1:0]  merged;

  // Bit offset of the slice selected by the counter.
  assign off     = OffW'(cnt_q * CHUNK);
  assign slice_a = a_q[off +: CHUNK];
  assign slice_b = b_q[off +: CHUNK];

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .s_o    (slice_s),
    .cout_o (slice_cout),
    .cmsb_o (slice_cmsb)
  );

  // Working sum with the current slice result patched in.
  always_comb begin
    merged             = work_q;
    merged[off +: CHUNK] = slice_s;
  end

  // Next-state, datapath load and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    work_d  = work_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ov_d    = ov_q;
    zero_d  = zero_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          // Subtract as x + ~y + 1: invert y here, seed the carry with 1.
          state_d = StRun;
          a_d     = x_i;
          b_d     = y_i ^ {WIDTH{sub_i}};
          carry_d = sub_i;
          cnt_d   = '0;
          work_d  = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        work_d  = merged;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          // Last slice holds the MSB, so its carries give cout and ov.
          state_d = StDone;
          cnt_d   = '0;
          sum_d   = merged;
          cout_d  = slice_cout;
          ov_d    = slice_cmsb ^ slice_cout;
          zero_d  = (merged == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ov_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ov_q    <= ov_d;
      zero_q  <= zero_d;
    end
  end

  assign busy_o = (state_q == StRun);
  assign done_o = (state_q == StDone);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ov_o   = ov_q;
  assign zero_o = zero_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub: four configurations (32/8, 32/32, 32/1, 16/4)
// checked against an arithmetic reference model.
module tb_seq_addsub;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Per-instance configuration: 0=32/8, 1=32/32, 2=32/1, 3=16/4
  int unsigned wid   [4] = '{32, 32, 32, 16};
  int unsigned nch_c [4] = '{4, 1, 32, 4};

  logic        start_v [4];
  logic        sub_v   [4];
  logic [31:0] x_v     [4];
  logic [31:0] y_v     [4];
  logic        busy_v  [4];
  logic        done_v  [4];
  logic        cout_v  [4];
  logic        ov_v    [4];
  logic        zero_v  [4];
  logic [31:0] s0, s1, s2;
  logic [15:0] s3;
  logic [31:0] sum_v   [4];

  always_comb begin
    sum_v[0] = s0;
    sum_v[1] = s1;
    sum_v[2] = s2;
    sum_v[3] = {16'h0, s3};
  end

  logic [31:0] exp_sum [4];
  logic        exp_c   [4];
  logic        exp_v   [4];
  logic        exp_z   [4];
  int unsigned done_at [4];

  seq_addsub #(.WIDTH(32), .CHUNK(8)) u_w32c8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_v[0]), .sub_i(sub_v[0]),
    .x_i(x_v[0]), .y_i(y_v[0]), .busy_o(busy_v[0]), .done_o(done_v[0]),
    .sum_o(s0), .cout_o(cout_v[0]), .ov_o(ov_v[0]), .zero_o(zero_v[0])
  );
  seq_addsub #(.WIDTH(32), .CHUNK(32)) u_w32c32 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_v[1]), .sub_i(sub_v[1]),
    .x_i(x_v[1]), .y_i(y_v[1]), .busy_o(busy_v[1]), .done_o(done_v[1]),
    .sum_o(s1), .cout_o(cout_v[1]), .ov_o(ov_v[1]), .zero_o(zero_v[1])
  );
  seq_addsub #(.WIDTH(32), .CHUNK(1)) u_w32c1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_v[2]), .sub_i(sub_v[2]),
    .x_i(x_v[2]), .y_i(y_v[2]), .busy_o(busy_v[2]), .done_o(done_v[2]),
    .sum_o(s2), .cout_o(cout_v[2]), .ov_o(ov_v[2]), .zero_o(zero_v[2])
  );
  seq_addsub #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_v[3]), .sub_i(sub_v[3]),
    .x_i(x_v[3][15:0]), .y_i(y_v[3][15:0]), .busy_o(busy_v[3]), .done_o(done_v[3]),
    .sum_o(s3), .cout_o(cout_v[3]), .ov_o(ov_v[3]), .zero_o(zero_v[3])
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic on unsigned and signed views of the operands.
  function automatic void ref_model(input int unsigned w, input bit s,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output bit c,
                                    output bit v, output bit z);
    longint modv, half, ua, ub, full, sa, sb, res;
    modv = longint'(1) << w;
    half = modv / 2;
    ua   = longint'({32'h0, a}) % modv;
    ub   = longint'({32'h0, b}) % modv;
    if (s) begin
      c    = (ua >= ub);
      full = ua - ub;
      if (full < 0) full = full + modv;
    end else begin
      full = ua + ub;
      c    = (full >= modv);
      full = full % modv;
    end
    r   = full[31:0];
    sa  = (ua >= half) ? ua - modv : ua;
    sb  = (ub >= half) ? ub - modv : ub;
    res = s ? sa - sb : sa + sb;
    v   = (res < -half) || (res >= half);
    z   = (full == 0);
  endfunction

  task automatic check_outs(input int k, input string tag);
    check_val({tag, ".sum"},  sum_v[k],  exp_sum[k]);
    check_val({tag, ".cout"}, cout_v[k], exp_c[k]);
    check_val({tag, ".ov"},   ov_v[k],   exp_v[k]);
    check_val({tag, ".zero"}, zero_v[k], exp_z[k]);
  endtask

  // Issue one operation on instance k; poke re-asserts start with junk mid-run.
  task automatic run_op(input int k, input bit s, input logic [31:0] a,
                        input logic [31:0] b, input bit poke);
    logic [31:0] r;
    bit c, v, z;
    int cyc;
    int budget;
    bit seen;
    ref_model(wid[k], s, a, b, r, c, v, z);
    budget = int'(nch_c[k]) + 4;
    seen   = 1'b0;
    @(negedge clk);
    start_v[k] = 1'b1; sub_v[k] = s; x_v[k] = a; y_v[k] = b;
    @(posedge clk); #1;
    check_val("run.busy_e0", busy_v[k], 1'b1);
    for (cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      start_v[k] = poke && (cyc == 1);
      sub_v[k]   = 1'($urandom);
      x_v[k]     = $urandom;
      y_v[k]     = $urandom;
      @(posedge clk); #1;
      if (done_v[k]) begin
        seen = 1'b1;
        break;
      end
      check_val("run.busy", busy_v[k], 1'b1);
      check_val("run.hold", sum_v[k], exp_sum[k]);
    end
    if (!seen) begin
      check_val("run.timeout", 1'b0, 1'b1);
      return;
    end
    done_at[k] = cyc_cnt;
    check_val("run.latency", cyc, nch_c[k]);
    check_val("run.busy_done", busy_v[k], 1'b0);
    exp_sum[k] = r; exp_c[k] = c; exp_v[k] = v; exp_z[k] = z;
    check_outs(k, "run");
  endtask

  // Idle cycles after done: pulse must drop, results must hold.
  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check_val("idle.done", done_v[k], 1'b0);
      check_val("idle.busy", busy_v[k], 1'b0);
      check_val("idle.hold", sum_v[k], exp_sum[k]);
    end
  endtask

  task automatic clear_exp();
    for (int k = 0; k < 4; k++) begin
      exp_sum[k] = '0; exp_c[k] = 1'b0; exp_v[k] = 1'b0; exp_z[k] = 1'b0;
    end
  endtask

  int unsigned t_first;

  initial begin
    for (int k = 0; k < 4; k++) begin
      start_v[k] = 1'b0; sub_v[k] = 1'b0; x_v[k] = '0; y_v[k] = '0; done_at[k] = 0;
    end
    clear_exp();
    rst_n = 1'b0;
    #12;
    for (int k = 0; k < 4; k++) begin
      check_val("rst.busy", busy_v[k], 1'b0);
      check_val("rst.done", done_v[k], 1'b0);
      check_outs(k, "rst");
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases on 32/8
    run_op(0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(0, 1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0);
    run_op(0, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0);
    idle(0, 1);
    t_first = done_at[0];
    run_op(0, 1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    check_val("b2b.gap_idle", done_at[0] - t_first > 5, 1'b1);
    t_first = done_at[0];
    run_op(0, 1'b1, 32'h0001_0000, 32'h0000_0001, 1'b0);
    check_val("b2b.period", done_at[0] - t_first, 5);
    run_op(0, 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1);
    idle(0, 2);

    // Reset in the second RUN cycle aborts without a done pulse
    @(negedge clk);
    start_v[0] = 1'b1; sub_v[0] = 1'b0; x_v[0] = 32'hA5A5_0000; y_v[0] = 32'h0000_5A5A;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    clear_exp();
    check_val("abort.busy", busy_v[0], 1'b0);
    check_val("abort.done", done_v[0], 1'b0);
    check_outs(0, "abort");
    repeat (3) begin
      @(posedge clk); #1;
      check_val("abort.nodone", done_v[0], 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 1'b0, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0);

    for (int i = 0; i < 20; i++) begin
      run_op(0, 1'($urandom), $urandom, $urandom, 1'($urandom));
      idle(0, int'($urandom_range(0, 2)));
    end

    // 32/32: single-cycle slices
    run_op(1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    t_first = done_at[1];
    run_op(1, 1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0);
    check_val("b2b1.period", done_at[1] - t_first, 2);
    for (int i = 0; i < 10; i++) begin
      run_op(1, 1'($urandom), $urandom, $urandom, 1'b0);
      idle(1, int'($urandom_range(0, 1)));
    end

    // 32/1: bit-serial
    run_op(2, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    run_op(2, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0);
    run_op(2, 1'($urandom), $urandom, $urandom, 1'b0);

    // 16/4: equal operands then randomised
    run_op(3, 1'b1, 32'h0000_BEEF, 32'h0000_BEEF, 1'b0);
    for (int i = 0; i < 200; i++) begin
      run_op(3, 1'($urandom), $urandom, $urandom, 1'($urandom));
      if (($urandom % 4) == 0) idle(3, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
